// File: rtl/wb_serializer_fifo_pkg.sv
// Register map, control-field layout and FSM encoding shared by the Wishbone serializer.
package wb_serializer_fifo_pkg;

    localparam logic [1:0] ADR_TXDATA = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;

    localparam int CTRL_TX_EN  = 16;
    localparam int CTRL_IRQ_EN = 17;
    localparam int CTRL_FLUSH  = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    typedef struct packed {
        logic irq_en;
        logic tx_en;
    } ctrl_t;

    function automatic logic [31:0] status_word(input logic [7:0] count, input logic busy,
                                                input logic full, input logic empty);
        return {16'h0, count, 5'b0, busy, full, empty};
    endfunction

endpackage

// File: rtl/wb_ser_fifo.sv
// Synchronous TX FIFO with flush; occupancy count runs 0..DEPTH, pointers wrap modulo DEPTH.
module wb_ser_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign dout_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_serializer_fifo.sv
// Wishbone-slave serial transmitter: queued words shifted out MSB-first at a programmable bit rate.
module wb_serializer_fifo #(
    parameter int SYM_W      = 9,
    parameter int NUM_SYM    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        data_o,
    output logic        ena_o,
    output logic        irq_o
);

    import wb_serializer_fifo_pkg::*;

    localparam int WORD_W = NUM_SYM * SYM_W;
    localparam int BW     = $clog2(WORD_W);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_dat;
    ctrl_t             r_ctrl;
    logic [DIV_W-1:0]  r_div;
    ser_state_t        r_state;
    ser_state_t        w_next;
    logic [WORD_W-1:0] r_shreg;
    logic [BW-1:0]     r_bitcnt;
    logic [DIV_W-1:0]  r_div_lat;
    logic [DIV_W-1:0]  r_div_cnt;

    logic              w_req;
    logic              w_push;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_err;
    logic [31:0]       w_rdata;
    logic [31:0]       w_ctrl_rd;
    logic [31:0]       w_status;
    logic              w_pop;
    logic              w_busy;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [WORD_W-1:0] w_head;
    logic              w_start;
    logic              w_period_end;
    logic              w_unused;

    assign w_unused = ^{ADR_I, DAT_I};

    wb_ser_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .din_i   (DAT_I[WORD_W-1:0]),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // A request is only seen while no response is pending, so each access has one side effect.
    assign w_req    = CYC_I & STB_I & ~(r_ack | r_err);
    assign w_flush  = w_ctrl_wr & DAT_I[CTRL_FLUSH];
    assign w_status = status_word(8'(w_count), w_busy, w_full, w_empty);

    always_comb begin
        w_ctrl_rd                 = '0;
        w_ctrl_rd[DIV_W-1:0]      = r_div;
        w_ctrl_rd[CTRL_TX_EN]     = r_ctrl.tx_en;
        w_ctrl_rd[CTRL_IRQ_EN]    = r_ctrl.irq_en;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_push    = 1'b0;
        w_ctrl_wr = 1'b0;
        w_err     = 1'b0;
        w_rdata   = '0;
        if (w_req) begin
            case (ADR_I[3:2])
                ADR_TXDATA: begin
                    if (WE_I) begin
                        if (w_full) w_err  = 1'b1;
                        else        w_push = 1'b1;
                    end
                end
                ADR_STATUS: begin
                    if (WE_I) w_err   = 1'b1;
                    else      w_rdata = w_status;
                end
                ADR_CTRL: begin
                    if (WE_I) w_ctrl_wr = 1'b1;
                    else      w_rdata   = w_ctrl_rd;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_dat  <= '0;
            r_ctrl <= '0;
            r_div  <= '0;
        end else begin
            r_ack <= w_req & ~w_err;
            r_err <= w_err;
            r_dat <= w_rdata;
            if (w_ctrl_wr) begin
                r_div         <= DAT_I[DIV_W-1:0];
                r_ctrl.tx_en  <= DAT_I[CTRL_TX_EN];
                r_ctrl.irq_en <= DAT_I[CTRL_IRQ_EN];
            end
        end
    end

    assign ACK_O = r_ack;
    assign ERR_O = r_err;
    assign DAT_O = r_dat;

    // A flush in flight suppresses the next LOAD so it never pops a just-emptied FIFO.
    assign w_start      = r_ctrl.tx_en & ~w_empty & ~w_flush;
    assign w_period_end = (r_div_cnt == r_div_lat);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_start) w_next = LOAD;
            LOAD:  w_next = SHIFT;
            SHIFT: begin
                if (w_period_end && (r_bitcnt == '0)) w_next = w_start ? LOAD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop  = (r_state == LOAD);
        w_busy = (r_state != IDLE);
        ena_o  = (r_state == SHIFT);
        data_o = (r_state == SHIFT) ? r_shreg[WORD_W-1] : 1'b0;
    end

    assign irq_o = w_empty & (r_state == IDLE) & r_ctrl.irq_en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_div_lat <= '0;
            r_div_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_shreg   <= w_head;
            r_bitcnt  <= BW'(WORD_W - 1);
            r_div_lat <= r_div;
            r_div_cnt <= '0;
        end else if (r_state == SHIFT) begin
            if (w_period_end) begin
                r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                r_bitcnt  <= r_bitcnt - 1'b1;
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

endmodule
